serial_word_rx: RTL and testbench

Serial-to-parallel word receiver for the far end of a link fed by our 4-bit universal shift register operating as a serializer. It takes one bit per qualified clock, left- or right-shifting it into an assembly register, and counts bits to frame WIDTH-bit words. Each completed word goes into a one-deep output buffer with a valid/ready handshake. The block also provides a sticky overrun flag and a bit-sync input for realigning to the transmitter.

---
 rtl/serial_word_rx.sv | 129 ++++++++++++
 tb/tb_serial_word_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_rx.sv
// serial_word_rx
//
// Serial-to-parallel word receiver. Accepts one bit per clock when
// sin_valid is high and shifts it into an assembly register. The bit order
// (LSB-first or MSB-first) is captured at the first bit of each word. Every
// WIDTH accepted bits form a word, which goes into a one-deep output buffer
// with a valid/ready handshake.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous, active-high reset
//   sin         serial data bit
//   sin_valid   sin is sampled on this edge
//   lsb_first   1: first bit lands in dout[0]; 0: first bit lands in dout[WIDTH-1]
//   sync        discard the partial word and restart framing (overrides sin_valid)
//   ovr_clr     clear the sticky overrun flag (a same-edge set wins)
//   dout        received word, stable while dout_valid is high
//   dout_valid  dout holds an unconsumed word
//   dout_ready  consumer accepts dout on this edge
//   overrun     sticky: a completed word was dropped because the buffer was full
//   bits        bit count of the current partial word (0..WIDTH-1)
//
// Handshake: a transfer happens on every rising edge where dout_valid and
// dout_ready are both high. dout is held constant from the edge that raises
// dout_valid until the edge of the transfer. dout_ready may be high while
// dout_valid is low, and it has no effect then.

module serial_word_rx #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             lsb_first,
    input  logic             sync,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    output logic [CW-1:0]    bits
);

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    bits_q, bits_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overrun_q, overrun_d;

    logic             accept;
    logic             word_start;
    logic             eff_mode;
    logic             word_done;
    logic             transfer;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        accept     = sin_valid && !sync;
        word_start = (bits_q == '0);
        // The first bit of a word uses lsb_first directly, because mode is
        // only being captured on that same edge.
        eff_mode   = word_start ? lsb_first : mode_q;
        shifted    = eff_mode ? {sin, sh_q[WIDTH-1:1]} : {sh_q[WIDTH-2:0], sin};
        word_done  = accept && (bits_q == CW'(WIDTH - 1));
        transfer   = dout_valid_q && dout_ready;

        sh_d         = sh_q;
        bits_d       = bits_q;
        mode_d       = mode_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;

        if (sin_valid && word_start) begin
            mode_d = lsb_first;
        end

        if (sync) begin
            sh_d   = '0;
            bits_d = '0;
        end else if (accept) begin
            sh_d   = shifted;
            bits_d = word_done ? '0 : bits_q + CW'(1);
        end

        if (ovr_clr) begin
            overrun_d = 1'b0;
        end

        if (word_done) begin
            if (!dout_valid_q || transfer) begin
                dout_d       = shifted;
                dout_valid_d = 1'b1;
            end else begin
                // Buffer full and not draining: drop the new word.
                overrun_d = 1'b1;
            end
        end else if (transfer) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q         <= '0;
            bits_q       <= '0;
            mode_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sh_q         <= sh_d;
            bits_q       <= bits_d;
            mode_q       <= mode_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;
    assign bits       = bits_q;

endmodule

// File: tb/tb_serial_word_rx.sv
// Testbench for serial_word_rx (WIDTH=4): directed vector table followed by
// randomized stimulus checked against a bit-queue reference model.

module tb_serial_word_rx;

    localparam int W  = 4;
    localparam int CW = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          sin = 1'b0;
    logic          sin_valid = 1'b0;
    logic          lsb_first = 1'b0;
    logic          sync = 1'b0;
    logic          ovr_clr = 1'b0;
    logic          dout_ready = 1'b0;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic          overrun;
    logic [CW-1:0] bits;

    serial_word_rx #(.WIDTH(W), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .lsb_first  (lsb_first),
        .sync       (sync),
        .ovr_clr    (ovr_clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun),
        .bits       (bits)
    );

    // ---------------- check bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          rst, sv, sin, lsb, syn, clr, rdy;
        logic [W-1:0]  e_dout;
        logic          e_dv, e_ovr;
        logic [CW-1:0] e_bits;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic s, input logic l,
                       input logic y, input logic c, input logic rd,
                       input logic [W-1:0] ed, input logic edv, input logic eo,
                       input logic [CW-1:0] eb);
        vec_t t;
        t.rst = r; t.sv = v; t.sin = s; t.lsb = l; t.syn = y; t.clr = c; t.rdy = rd;
        t.e_dout = ed; t.e_dv = edv; t.e_ovr = eo; t.e_bits = eb;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic r, input logic v, input logic s, input logic l,
                         input logic y, input logic c, input logic rd);
        rst = r; sin_valid = v; sin = s; lsb_first = l; sync = y; ovr_clr = c; dout_ready = rd;
    endtask

    // ---------------- reference model ----------------
    logic       m_q[$];
    logic       m_lsb;
    logic [W-1:0] m_dout;
    logic       m_dv, m_ovr;

    task automatic model_step(input logic r, input logic v, input logic s, input logic l,
                              input logic y, input logic c, input logic rd);
        logic xfer, done, set_ovr;
        logic [W-1:0] word;
        if (r) begin
            m_q.delete(); m_lsb = 1'b0; m_dout = '0; m_dv = 1'b0; m_ovr = 1'b0;
            return;
        end
        xfer = m_dv && rd;
        done = 1'b0;
        set_ovr = 1'b0;
        word = '0;
        if (y) begin
            m_q.delete();
        end else if (v) begin
            if (m_q.size() == 0) m_lsb = l;
            m_q.push_back(s);
            if (m_q.size() == W) begin
                // i-th received bit goes to position i (LSB-first) or W-1-i.
                for (int i = 0; i < W; i++) begin
                    if (m_lsb) word[i] = m_q[i];
                    else       word[W-1-i] = m_q[i];
                end
                done = 1'b1;
                m_q.delete();
            end
        end
        if (done) begin
            if (!m_dv || xfer) begin
                m_dout = word; m_dv = 1'b1;
            end else begin
                set_ovr = 1'b1;
            end
        end else if (xfer) begin
            m_dv = 1'b0;
        end
        if (c) m_ovr = 1'b0;
        if (set_ovr) m_ovr = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        // rst sv sin lsb sync clr rdy | dout dv ovr bits
        add(1,0,0,0,0,0,0, 4'h0,0,0,0);   // reset
        // MSB-first 1,0,1,1 -> 1011
        add(0,1,1,0,0,0,1, 4'h0,0,0,1);
        add(0,1,0,0,0,0,1, 4'h0,0,0,2);
        add(0,1,1,0,0,0,1, 4'h0,0,0,3);
        add(0,1,1,0,0,0,1, 4'hB,1,0,0);
        add(0,0,0,0,0,0,1, 4'hB,0,0,0);   // consumed, dout held
        // LSB-first 1,0,1,1 -> 1101
        add(0,1,1,1,0,0,1, 4'hB,0,0,1);
        add(0,1,0,1,0,0,1, 4'hB,0,0,2);
        add(0,1,1,1,0,0,1, 4'hB,0,0,3);
        add(0,1,1,1,0,0,1, 4'hD,1,0,0);
        // LSB-first word 1,0,0,0 with lsb_first dropped after bit 1 -> 0001
        add(0,1,1,1,0,0,1, 4'hD,0,0,1);
        add(0,1,0,0,0,0,1, 4'hD,0,0,2);
        add(0,1,0,0,0,0,1, 4'hD,0,0,3);
        add(0,1,0,0,0,0,1, 4'h1,1,0,0);
        // Overrun: A then 5 with consumer stalled
        add(0,1,1,0,0,0,1, 4'h1,0,0,1);
        add(0,1,0,0,0,0,0, 4'h1,0,0,2);
        add(0,1,1,0,0,0,0, 4'h1,0,0,3);
        add(0,1,0,0,0,0,0, 4'hA,1,0,0);
        add(0,1,0,0,0,0,0, 4'hA,1,0,1);
        add(0,1,1,0,0,0,0, 4'hA,1,0,2);
        add(0,1,0,0,0,0,0, 4'hA,1,0,3);
        add(0,1,1,0,0,0,0, 4'hA,1,1,0);   // 5 dropped
        add(0,0,0,0,0,0,1, 4'hA,0,1,0);   // release
        add(0,0,0,0,0,0,0, 4'hA,0,1,0);   // still sticky
        add(0,0,0,0,0,1,0, 4'hA,0,0,0);   // cleared
        // Simultaneous: 3 pending, C completes on the transfer edge
        add(0,1,0,0,0,0,0, 4'hA,0,0,1);
        add(0,1,0,0,0,0,0, 4'hA,0,0,2);
        add(0,1,1,0,0,0,0, 4'hA,0,0,3);
        add(0,1,1,0,0,0,0, 4'h3,1,0,0);
        add(0,1,1,0,0,0,0, 4'h3,1,0,1);
        add(0,1,1,0,0,0,0, 4'h3,1,0,2);
        add(0,1,0,0,0,0,0, 4'h3,1,0,3);
        add(0,1,0,0,0,0,1, 4'hC,1,0,0);
        // Overrun set and ovr_clr on same edge: set wins
        add(0,1,1,0,0,0,0, 4'hC,1,0,1);
        add(0,1,1,0,0,0,0, 4'hC,1,0,2);
        add(0,1,1,0,0,0,0, 4'hC,1,0,3);
        add(0,1,1,0,0,1,0, 4'hC,1,1,0);
        add(0,0,0,0,0,1,1, 4'hC,0,0,0);
        // Sync: 2 bits, sync with sin_valid, then 0,1,1,0 -> 6
        add(0,1,1,0,0,0,0, 4'hC,0,0,1);
        add(0,1,1,0,0,0,0, 4'hC,0,0,2);
        add(0,1,1,0,1,0,0, 4'hC,0,0,0);
        add(0,1,0,0,0,0,0, 4'hC,0,0,1);
        add(0,1,1,0,0,0,0, 4'hC,0,0,2);
        add(0,1,1,0,0,0,0, 4'hC,0,0,3);
        add(0,1,0,0,0,0,0, 4'h6,1,0,0);
        // Reset mid-operation: overrun, 3 partial bits, then rst
        add(0,1,0,0,0,0,0, 4'h6,1,0,1);
        add(0,1,0,0,0,0,0, 4'h6,1,0,2);
        add(0,1,0,0,0,0,0, 4'h6,1,0,3);
        add(0,1,0,0,0,0,0, 4'h6,1,1,0);
        add(0,1,1,0,0,0,0, 4'h6,1,1,1);
        add(0,1,1,0,0,0,0, 4'h6,1,1,2);
        add(0,1,1,0,0,0,0, 4'h6,1,1,3);
        add(1,1,1,0,0,0,0, 4'h0,0,0,0);
        add(0,1,1,0,0,0,0, 4'h0,0,0,1);
        add(0,1,1,0,0,0,0, 4'h0,0,0,2);
        add(0,1,1,0,0,0,0, 4'h0,0,0,3);
        add(0,1,0,0,0,0,0, 4'hE,1,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].sv, vecs[i].sin, vecs[i].lsb,
                  vecs[i].syn, vecs[i].clr, vecs[i].rdy);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].e_dout));
            check($sformatf("vec%0d_dout_valid", i), 32'(dout_valid), 32'(vecs[i].e_dv));
            check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(vecs[i].e_ovr));
            check($sformatf("vec%0d_bits", i), 32'(bits), 32'(vecs[i].e_bits));
        end

        // Randomized phase, starting from a reset.
        for (int n = 0; n < 3000; n++) begin
            logic r, v, s, l, y, c, rd;
            r  = (n == 0) || ($urandom_range(0, 299) == 0);
            v  = ($urandom_range(0, 3) != 0);
            s  = 1'($urandom_range(0, 1));
            l  = 1'($urandom_range(0, 1));
            y  = ($urandom_range(0, 39) == 0);
            c  = ($urandom_range(0, 15) == 0);
            rd = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            drive(r, v, s, l, y, c, rd);
            model_step(r, v, s, l, y, c, rd);
            @(posedge clk);
            #1;
            check("rnd_dout", 32'(dout), 32'(m_dout));
            check("rnd_dout_valid", 32'(dout_valid), 32'(m_dv));
            check("rnd_overrun", 32'(overrun), 32'(m_ovr));
            check("rnd_bits", 32'(bits), 32'(m_q.size()));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
